// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the hazard, bypass and writeback stages.
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_idx_t ZERO_REG = 5'd0;

  // True when an enabled write targets index idx; r0 never matches.
  function automatic logic write_hits(input logic en, input reg_idx_t wr, input reg_idx_t idx);
    return en && (wr != ZERO_REG) && (wr == idx);
  endfunction

endpackage

// File: rtl/regfile_reg.sv
// Single register with write enable and asynchronous active-high clear.
module regfile_reg #(
  parameter int DATA_W = regfile_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_32x32.sv
// 32 x 32-bit architectural register file: one-hot write decode, two combinational read ports.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_32x32
  import regfile_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB
);

  logic [NUM_REGS-1:1]             wr_sel;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  // Enable gates the decode first, so an unknown index with enable low selects nothing.
  always_comb begin
    wr_sel = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      wr_sel[i] = write_hits(ctrl_writeEnable, ctrl_writeReg, reg_idx_t'(i));
    end
  end

  assign regs[0] = '0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
    regfile_reg #(
      .DATA_W(DATA_W)
    ) u_reg (
      .clock(clock),
      .reset(reset),
      .en   (wr_sel[g]),
      .d    (data_writeReg),
      .q    (regs[g])
    );
  end

`ifdef REGFILE_BYPASS_EN
  logic byp_a;
  logic byp_b;

  // Forwarding is suppressed under reset so reads still show the cleared array.
  assign byp_a = !reset && write_hits(ctrl_writeEnable, ctrl_writeReg, ctrl_readRegA);
  assign byp_b = !reset && write_hits(ctrl_writeEnable, ctrl_writeReg, ctrl_readRegB);

  assign data_readRegA = byp_a ? data_writeReg : regs[ctrl_readRegA];
  assign data_readRegB = byp_b ? data_writeReg : regs[ctrl_readRegB];
`else
  assign data_readRegA = regs[ctrl_readRegA];
  assign data_readRegB = regs[ctrl_readRegB];
`endif

endmodule
